clk_wiz_vio: RTL and testbench
==============================

CLK_WIZ_VIO -- requirements
Module: clk_wiz_vio

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter DIV_HALF, default 2: clk_out1 half-period, in clk_in1 cycles; legal range 1..255.
REQ-003 Parameter LOCK_CYCLES, default 16: clk_in1 cycles from reset release to lock; legal range 1..65535.
REQ-004 Parameter PROBE_W, default 32: width of the probe paths.
REQ-005 clk_in1  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk_out1  output  1  derived clock; driven directly from a register, never from combinational logic.
REQ-008 locked  output  1  high when clk_out1 is stable.
REQ-009 probe_in0  input  PROBE_W  monitored value.
REQ-010 probe_cap  output  PROBE_W  last captured value of probe_in0.
REQ-011 probe_chg  output  1  one-cycle pulse when a capture differs from the previous capture.
REQ-012 probe_cnt  output  16  number of captures taken.
REQ-013 host_we  input  1  write strobe for probe_out0.
REQ-014 host_wdata  input  PROBE_W  write data for probe_out0.
REQ-015 probe_out0  output  PROBE_W  host-driven virtual output.

Function
REQ-016 An internal 16-bit lock counter SHALL increment on every edge where reset=0 and locked=0.
REQ-017 locked SHALL be registered and SHALL rise on the edge where the lock counter reaches LOCK_CYCLES.
- locked is therefore first high after exactly LOCK_CYCLES edges with reset low.
REQ-018 Once high, locked SHALL stay high until reset.
REQ-019 clk_out1 SHALL be held 0 while locked=0.
REQ-020 Clock divider, while locked=1:
- 8-bit divider counter; clk_out1 toggles on each edge where the counter equals DIV_HALF-1.
- The counter returns to 0 on each toggle and otherwise increments.
REQ-021 The first 0->1 transition of clk_out1 SHALL occur DIV_HALF edges after the edge on which locked rises.
- clk_out1 period = 2*DIV_HALF clk_in1 cycles, 50% duty.
REQ-022 A capture event is the clk_in1 edge on which the clk_out1 register changes from 0 to 1. On a capture event:
- probe_cap <= probe_in0 sampled at that edge.
- probe_cnt <= probe_cnt+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-023 probe_chg SHALL be 1 for exactly the one cycle following a capture whose value differs from the prior probe_cap; otherwise 0.
- The first capture after reset compares against the reset value 0.
REQ-024 No capture SHALL occur while locked=0.
- Changes on probe_in0 between capture events SHALL have no effect on any output.
REQ-025 probe_out0 SHALL load host_wdata on every edge with host_we=1, and hold otherwise.
- probe_out0 is independent of locked and of capture events.

Reset
REQ-026 With reset=1 at an edge, the block SHALL load: locked=0, clk_out1=0, lock and divider counters=0, probe_cap=0, probe_chg=0, probe_cnt=0, probe_out0=0.
REQ-027 Reset SHALL take priority over host_we and over capture events on the same edge.
REQ-028 Reset asserted mid-operation SHALL drop locked and clk_out1 on that edge.
- The full LOCK_CYCLES sequence then restarts after release.

Verification
REQ-029 Lock timing (LOCK_CYCLES=16, DIV_HALF=2): release reset -> locked=0 for 15 edges, 1 after the 16th; clk_out1 first high 2 edges later; clk_out1 period 4 cycles.
REQ-030 Capture: probe_in0=0x0000_00A5 held -> first capture gives probe_cap=0xA5, probe_chg pulse of 1 cycle, probe_cnt=1; second capture gives probe_chg=0, probe_cnt=2.
REQ-031 Inter-capture glitch: probe_in0 toggles 0x1234->0xFFFF->0x1234 between two capture edges -> probe_cap stays 0x1234, probe_chg=0.
REQ-032 Wrap: force 65536 captures -> probe_cnt returns to 0x0000 with no other side effects.
REQ-033 Host write: host_we=1 with host_wdata=0xDEAD_BEEF before lock -> probe_out0=0xDEAD_BEEF next cycle; host_we=1 together with reset=1 -> probe_out0=0.
REQ-034 Mid-run reset: assert reset for 1 cycle while clk_out1=1 -> clk_out1=0, locked=0, probe_cnt=0; relock after 16 edges.

Source files
------------

// File: rtl/clk_wiz_vio_if.sv
// ---------------------------------------------------------------------------
// clk_wiz_vio_if
// Probe and host bus for clk_wiz_vio. The monitored input, the capture
// results and the host-written virtual output are grouped here. The clock,
// the reset, clk_out1 and locked stay as plain ports on the block.
//
// Signals:
//   probe_in0  [PROBE_W]  monitored value, driven by the master
//   probe_cap  [PROBE_W]  last captured probe_in0
//   probe_chg  [1]        one-cycle pulse after a capture that changed value
//   probe_cnt  [16]       number of captures taken, wraps at 2^16
//   host_we    [1]        write strobe for probe_out0
//   host_wdata [PROBE_W]  write data for probe_out0
//   probe_out0 [PROBE_W]  host-driven virtual output
//
// Modports:
//   master  the host/observer side (testbench or debug hub)
//   slave   clk_wiz_vio
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface clk_wiz_vio_if #(
    parameter int PROBE_W = 32
);
    logic [PROBE_W-1:0] probe_in0;
    logic [PROBE_W-1:0] probe_cap;
    logic               probe_chg;
    logic [15:0]        probe_cnt;
    logic               host_we;
    logic [PROBE_W-1:0] host_wdata;
    logic [PROBE_W-1:0] probe_out0;

    modport master (
        output probe_in0,
        output host_we,
        output host_wdata,
        input  probe_cap,
        input  probe_chg,
        input  probe_cnt,
        input  probe_out0
    );

    modport slave (
        input  probe_in0,
        input  host_we,
        input  host_wdata,
        output probe_cap,
        output probe_chg,
        output probe_cnt,
        output probe_out0
    );
endinterface

// File: rtl/clk_wiz_vio.sv
// ---------------------------------------------------------------------------
// clk_wiz_vio
// Behavioural stand-in for a clock wizard plus virtual I/O probe block.
// After reset is released, a lock counter runs for LOCK_CYCLES clk_in1 edges
// and then asserts locked. Once locked, clk_out1 is divided from clk_in1 with
// a half-period of DIV_HALF cycles. Each rising edge of clk_out1 captures
// probe_in0 into probe_cap, counts the capture in probe_cnt and pulses
// probe_chg if the captured value changed. probe_out0 is a host-written
// register that ignores lock and captures entirely.
//
// Ports:
//   clk_in1   in   sole clock, all state updates on its rising edge
//   reset     in   synchronous, active-high
//   clk_out1  out  divided clock, straight from a flop, low while unlocked
//   locked    out  high once the lock sequence has completed
//   bus       slave modport of clk_wiz_vio_if (probe and host signals)
//
// Lock FSM:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_LOCKING | counting clk_in1 edges since reset release, clk_out1 held 0
//   ST_LOCKED  | lock reached, divider running, captures enabled
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module clk_wiz_vio #(
    parameter int DIV_HALF    = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int PROBE_W     = 32
) (
    input  logic           clk_in1,
    input  logic           reset,
    output logic           clk_out1,
    output logic           locked,
    clk_wiz_vio_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_LOCKING = 1'b0,
        ST_LOCKED  = 1'b1
    } state_t;

    localparam logic [15:0] LOCK_TC = 16'(LOCK_CYCLES);
    localparam logic [7:0]  DIV_TC  = 8'(DIV_HALF - 1);

    state_t             state_q;
    state_t             state_d;

    logic [15:0]        lock_cnt_q;
    logic [15:0]        lock_cnt_inc;
    logic               lock_cnt_en;
    logic               div_en;

    logic [7:0]         div_cnt_q;
    logic               div_hit;
    logic               clk_out1_q;
    logic               cap_evt;

    logic [PROBE_W-1:0] probe_cap_q;
    logic               probe_chg_q;
    logic [15:0]        probe_cnt_q;
    logic [PROBE_W-1:0] probe_out0_q;

    // -----------------------------------------------------------------------
    // Lock FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q <= ST_LOCKING;
        end else begin
            state_q <= state_d;
        end
    end

    // The counter value after this edge is compared, so locked rises on the
    // very edge that brings the count to LOCK_CYCLES.
    assign lock_cnt_inc = lock_cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOCKING: begin
                if (lock_cnt_inc == LOCK_TC) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                state_d = ST_LOCKED;
            end
            default: begin
                state_d = ST_LOCKING;
            end
        endcase
    end

    always_comb begin
        locked      = 1'b0;
        lock_cnt_en = 1'b0;
        div_en      = 1'b0;
        case (state_q)
            ST_LOCKING: begin
                lock_cnt_en = 1'b1;
            end
            ST_LOCKED: begin
                locked = 1'b1;
                div_en = 1'b1;
            end
            default: begin
                lock_cnt_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            lock_cnt_q <= 16'd0;
        end else if (lock_cnt_en) begin
            lock_cnt_q <= lock_cnt_inc;
        end
    end

    // -----------------------------------------------------------------------
    // Clock divider
    // -----------------------------------------------------------------------
    assign div_hit = (div_cnt_q == DIV_TC);

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            div_cnt_q  <= 8'd0;
            clk_out1_q <= 1'b0;
        end else if (div_en) begin
            if (div_hit) begin
                div_cnt_q  <= 8'd0;
                clk_out1_q <= ~clk_out1_q;
            end else begin
                div_cnt_q <= div_cnt_q + 8'd1;
            end
        end
    end

    assign clk_out1 = clk_out1_q;

    // -----------------------------------------------------------------------
    // Probe capture: fires on the edge where the clk_out1 flop goes 0 -> 1
    // -----------------------------------------------------------------------
    assign cap_evt = div_en & div_hit & ~clk_out1_q;

    always_ff @(posedge clk_in1) begin
        if (reset) begin
            probe_cap_q <= '0;
            probe_chg_q <= 1'b0;
            probe_cnt_q <= 16'd0;
        end else if (cap_evt) begin
            probe_cap_q <= bus.probe_in0;
            probe_chg_q <= (bus.probe_in0 != probe_cap_q);
            probe_cnt_q <= probe_cnt_q + 16'd1;
        end else begin
            probe_chg_q <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Host-driven virtual output
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            probe_out0_q <= '0;
        end else if (bus.host_we) begin
            probe_out0_q <= bus.host_wdata;
        end
    end

    assign bus.probe_cap  = probe_cap_q;
    assign bus.probe_chg  = probe_chg_q;
    assign bus.probe_cnt  = probe_cnt_q;
    assign bus.probe_out0 = probe_out0_q;

endmodule

// File: tb/tb_clk_wiz_vio.sv
`timescale 1ns/1ps

module tb_clk_wiz_vio;
    localparam int PW = 32;
    localparam int LC = 16;
    localparam int DH = 2;

    typedef struct packed {
        logic [PW-1:0] cap;
        logic          chg;
        logic [15:0]   cnt;
    } exp_t;

    logic clk_in1 = 1'b0;
    logic reset   = 1'b1;
    logic clk_out1;
    logic locked;

    clk_wiz_vio_if #(.PROBE_W(PW)) bus();

    clk_wiz_vio #(
        .DIV_HALF   (DH),
        .LOCK_CYCLES(LC),
        .PROBE_W    (PW)
    ) dut (
        .clk_in1 (clk_in1),
        .reset   (reset),
        .clk_out1(clk_out1),
        .locked  (locked),
        .bus     (bus)
    );

    always #5 clk_in1 = ~clk_in1;

    int cyc = 0;
    always @(posedge clk_in1) cyc <= cyc + 1;

    int            n_total = 0;
    int            n_pass  = 0;
    exp_t          sb[$];
    logic [PW-1:0] m_cap;
    logic [15:0]   m_cnt;
    int            last_evt_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    endtask

    // Reference model: one capture of value v.
    task automatic expect_capture(input logic [PW-1:0] v);
        exp_t e;
        e.cap = v;
        e.chg = (v != m_cap);
        m_cnt = m_cnt + 16'd1;
        e.cnt = m_cnt;
        m_cap = v;
        sb.push_back(e);
    endtask

    // Wait for the next clk_out1 rise, compare against the scoreboard head.
    // With tail set, also checks pulse width of probe_chg and 50% duty.
    task automatic next_capture(input int exp_gap, input bit tail);
        logic prev;
        bit   found;
        exp_t e;
        found = 1'b0;
        prev  = clk_out1;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk_in1); #1;
            if (!prev && clk_out1) found = 1'b1;
            prev = clk_out1;
        end
        if (!found) begin
            check("capture_timeout", 64'd0, 64'd1);
            return;
        end
        if (exp_gap != 0) check("capture_gap", 64'(cyc - last_evt_cyc), 64'(exp_gap));
        last_evt_cyc = cyc;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check("probe_cap", 64'(bus.probe_cap), 64'(e.cap));
        check("probe_chg", 64'(bus.probe_chg), 64'(e.chg));
        check("probe_cnt", 64'(bus.probe_cnt), 64'(e.cnt));
        if (tail) begin
            @(posedge clk_in1); #1;
            check("chg_pulse_width", 64'(bus.probe_chg), 64'd0);
            check("clk_high_2nd", 64'(clk_out1), 64'd1);
            @(posedge clk_in1); #1;
            check("clk_fall", 64'(clk_out1), 64'd0);
        end
    endtask

    task automatic lock_sequence();
        for (int i = 1; i <= LC; i++) begin
            @(posedge clk_in1); #1;
            check("lock_timing", 64'(locked), 64'(i == LC));
            if (i == 1) begin
                check("host_write", 64'(bus.probe_out0), 64'(bus.host_wdata));
                bus.host_we = 1'b0;
            end
            if (i == LC - 1) begin
                check("clk_low_unlocked", 64'(clk_out1), 64'd0);
                check("no_capture_unlocked", 64'(bus.probe_cnt), 64'd0);
            end
            if (i == LC) last_evt_cyc = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.host_we    = 1'b0;
        bus.host_wdata = '0;
        bus.probe_in0  = 32'h0000_00A5;
        m_cap = '0;
        m_cnt = 16'd0;
        reset = 1'b1;

        repeat (2) @(posedge clk_in1);
        @(negedge clk_in1);
        bus.host_we    = 1'b1;
        bus.host_wdata = 32'hDEAD_BEEF;
        @(posedge clk_in1); #1;
        check("we_under_reset", 64'(bus.probe_out0), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_clk_out1", 64'(clk_out1), 64'd0);
        check("rst_probe_cap", 64'(bus.probe_cap), 64'd0);
        check("rst_probe_chg", 64'(bus.probe_chg), 64'd0);
        check("rst_probe_cnt", 64'(bus.probe_cnt), 64'd0);

        // Release with a host write pending on the first edge.
        @(negedge clk_in1);
        reset = 1'b0;
        lock_sequence();
        check("host_hold", 64'(bus.probe_out0), 64'h0000_0000_DEAD_BEEF);

        // Held 0xA5: first capture changes, second does not.
        expect_capture(32'h0000_00A5);
        next_capture(DH, 1'b1);
        expect_capture(32'h0000_00A5);
        next_capture(2 * DH, 1'b1);

        // Host write while locked; set up next probe value.
        bus.host_we    = 1'b1;
        bus.host_wdata = 32'h0BAD_F00D;
        bus.probe_in0  = 32'h0000_1234;
        @(posedge clk_in1); #1;
        bus.host_we = 1'b0;
        check("host_write_locked", 64'(bus.probe_out0), 64'h0000_0000_0BAD_F00D);
        expect_capture(32'h0000_1234);
        next_capture(2 * DH, 1'b1);

        // Glitch between captures.
        bus.probe_in0 = 32'hFFFF_FFFF;
        @(posedge clk_in1); #1;
        check("glitch_cap", 64'(bus.probe_cap), 64'h1234);
        check("glitch_chg", 64'(bus.probe_chg), 64'd0);
        bus.probe_in0 = 32'h0000_1234;
        expect_capture(32'h0000_1234);
        next_capture(2 * DH, 1'b1);

        // Wrap: preload the capture count just below 2^16.
        force dut.probe_cnt_q = 16'hFFFE;
        #1;
        release dut.probe_cnt_q;
        m_cnt = 16'hFFFE;
        expect_capture(32'h0000_1234);
        next_capture(2 * DH, 1'b1);
        expect_capture(32'h0000_1234);
        next_capture(2 * DH, 1'b1);
        check("wrap_locked", 64'(locked), 64'd1);
        check("wrap_out0", 64'(bus.probe_out0), 64'h0000_0000_0BAD_F00D);

        // Mid-run reset while clk_out1 is high.
        expect_capture(32'h0000_1234);
        next_capture(2 * DH, 1'b0);
        check("clk_high_pre_reset", 64'(clk_out1), 64'd1);
        reset = 1'b1;
        @(posedge clk_in1); #1;
        check("midrst_clk_out1", 64'(clk_out1), 64'd0);
        check("midrst_locked", 64'(locked), 64'd0);
        check("midrst_probe_cnt", 64'(bus.probe_cnt), 64'd0);
        check("midrst_probe_cap", 64'(bus.probe_cap), 64'd0);
        check("midrst_probe_out0", 64'(bus.probe_out0), 64'd0);
        m_cap = '0;
        m_cnt = 16'd0;
        reset = 1'b0;
        bus.host_we    = 1'b1;
        bus.host_wdata = 32'h5A5A_0001;
        lock_sequence();
        expect_capture(32'h0000_1234);
        next_capture(DH, 1'b1);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
